// File: rtl/spi_frame_decoder_if.sv
// Byte-stream and register-bank signals between the SPI front end, the frame
// decoder and the register file.
interface spi_frame_decoder_if #(
  parameter int ADDR_W     = 5,
  parameter int DATA_BYTES = 2
);
  localparam int DW = 8 * DATA_BYTES;

  logic [7:0]        data_in;
  logic              data_valid_in;
  logic              transaction_valid_in;
  logic [DW-1:0]     wr_data_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic              wr_valid_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic              rd_req_out;
  logic [DW-1:0]     rd_data_in;
  logic [7:0]        tx_data_out;
  logic              frame_error_out;

  modport slave (
    input  data_in, data_valid_in, transaction_valid_in, rd_data_in,
    output wr_data_out, wr_addr_out, wr_valid_out, rd_addr_out, rd_req_out,
           tx_data_out, frame_error_out
  );

  modport master (
    output data_in, data_valid_in, transaction_valid_in, rd_data_in,
    input  wr_data_out, wr_addr_out, wr_valid_out, rd_addr_out, rd_req_out,
           tx_data_out, frame_error_out
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// Turns SPI frames (header + MSB-first data words) into register-bank writes
// and reads, with optional auto-increment bursts and malformed-frame flagging.
module spi_frame_decoder #(
  parameter int ADDR_W     = 5,
  parameter int DATA_BYTES = 2,
  parameter bit BURST_EN   = 1'b1
) (
  input logic                clk_in,
  input logic                reset_in,
  spi_frame_decoder_if.slave bus
);
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_BYTES - 1);

  typedef enum logic [1:0] {HDR, WDATA, RDATA, DISCARD} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              burst_q;
  logic [DW-1:0]     word_q;
  logic [DW-1:0]     tx_q;
  logic [DW-1:0]     wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_valid_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_req_q;
  logic              rd_pend_q;
  logic              err_q;

  logic [DW-1:0]     word_d;
  logic [ADDR_W-1:0] addr_inc_d;
  logic              last_d;
  logic [7:0]        tx_byte_d;

  always_comb begin
    word_d     = (word_q << 8) | DW'(bus.data_in);
    addr_inc_d = addr_q + ADDR_W'(1);
    last_d     = (cnt_q == LAST);
    tx_byte_d  = 8'(tx_q >> (8 * (int'(LAST) - int'(cnt_q))));
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= HDR;
      cnt_q      <= '0;
      addr_q     <= '0;
      burst_q    <= 1'b0;
      word_q     <= '0;
      tx_q       <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      err_q      <= 1'b0;
      // Register file answers one cycle after the request; grab it then.
      rd_pend_q  <= rd_req_q;
      if (rd_pend_q) tx_q <= bus.rd_data_in;

      if (!bus.transaction_valid_in) begin
        if (state_q == WDATA && cnt_q != '0) err_q <= 1'b1;
        state_q <= HDR;
        cnt_q   <= '0;
      end else if (bus.data_valid_in) begin
        unique case (state_q)
          HDR: begin
            addr_q  <= bus.data_in[ADDR_W-1:0];
            burst_q <= BURST_EN & bus.data_in[6];
            cnt_q   <= '0;
            if (bus.data_in[7]) begin
              rd_req_q  <= 1'b1;
              rd_addr_q <= bus.data_in[ADDR_W-1:0];
              state_q   <= RDATA;
            end else begin
              state_q <= WDATA;
            end
          end
          WDATA: begin
            word_q <= word_d;
            if (last_d) begin
              cnt_q      <= '0;
              wr_valid_q <= 1'b1;
              wr_data_q  <= word_d;
              wr_addr_q  <= addr_q;
              if (burst_q) addr_q <= addr_inc_d;
              else         state_q <= DISCARD;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          RDATA: begin
            if (last_d) begin
              cnt_q <= '0;
              if (burst_q) begin
                addr_q    <= addr_inc_d;
                rd_addr_q <= addr_inc_d;
                rd_req_q  <= 1'b1;
              end else begin
                state_q <= DISCARD;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          DISCARD: err_q <= 1'b1;
        endcase
      end
    end
  end

  // Strobes are masked while reset is held so a pulse scheduled just before
  // reset never reaches the register file.
  assign bus.wr_data_out     = wr_data_q;
  assign bus.wr_addr_out     = wr_addr_q;
  assign bus.wr_valid_out    = wr_valid_q & ~reset_in;
  assign bus.rd_addr_out     = rd_addr_q;
  assign bus.rd_req_out      = rd_req_q & ~reset_in;
  assign bus.tx_data_out     = tx_byte_d;
  assign bus.frame_error_out = err_q & ~reset_in;
endmodule

// File: tb/tb_spi_frame_decoder.sv
// Drives directed SPI frames into three decoder configurations and checks them
// against a frame-level model of expected writes, reads, tx bytes and errors.
module tb_spi_frame_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  localparam int AW [3] = '{5, 5, 6};
  localparam int DB [3] = '{2, 2, 3};
  localparam int BE [3] = '{1, 0, 1};

  spi_frame_decoder_if #(.ADDR_W(5), .DATA_BYTES(2)) if0 ();
  spi_frame_decoder_if #(.ADDR_W(5), .DATA_BYTES(2)) if1 ();
  spi_frame_decoder_if #(.ADDR_W(6), .DATA_BYTES(3)) if2 ();

  spi_frame_decoder #(.ADDR_W(5), .DATA_BYTES(2), .BURST_EN(1)) d0 (.clk_in(clk), .reset_in(rst), .bus(if0));
  spi_frame_decoder #(.ADDR_W(5), .DATA_BYTES(2), .BURST_EN(0)) d1 (.clk_in(clk), .reset_in(rst), .bus(if1));
  spi_frame_decoder #(.ADDR_W(6), .DATA_BYTES(3), .BURST_EN(1)) d2 (.clk_in(clk), .reset_in(rst), .bus(if2));

  logic [7:0] din = 8'h00;
  logic       dv = 1'b0;
  logic       tv = 1'b0;
  int         sel = 0;

  always_comb begin
    if0.data_in = din; if0.data_valid_in = dv && sel == 0; if0.transaction_valid_in = tv && sel == 0;
    if1.data_in = din; if1.data_valid_in = dv && sel == 1; if1.transaction_valid_in = tv && sel == 1;
    if2.data_in = din; if2.data_valid_in = dv && sel == 2; if2.transaction_valid_in = tv && sel == 2;
  end

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return (a == 32'd3) ? 32'h00C0BEEF : (32'h00A1B2C3 ^ a);
  endfunction

  // Register file: data valid only in the cycle right after a request.
  always @(posedge clk) begin
    if (rst) begin
      if0.rd_data_in <= '0; if1.rd_data_in <= '0; if2.rd_data_in <= '0;
    end else begin
      if0.rd_data_in <= if0.rd_req_out ? 16'(rdw(32'(if0.rd_addr_out))) : 16'h5A5A;
      if1.rd_data_in <= if1.rd_req_out ? 16'(rdw(32'(if1.rd_addr_out))) : 16'h5A5A;
      if2.rd_data_in <= if2.rd_req_out ? 24'(rdw(32'(if2.rd_addr_out))) : 24'h5A5A5A;
    end
  end

  logic m_wv, m_rr, m_fe;
  logic [31:0] m_wa, m_wd, m_ra;
  logic [7:0]  m_tx;
  always_comb begin
    case (sel)
      0: begin m_wv = if0.wr_valid_out; m_wa = 32'(if0.wr_addr_out); m_wd = 32'(if0.wr_data_out);
               m_rr = if0.rd_req_out; m_ra = 32'(if0.rd_addr_out); m_tx = if0.tx_data_out; m_fe = if0.frame_error_out; end
      1: begin m_wv = if1.wr_valid_out; m_wa = 32'(if1.wr_addr_out); m_wd = 32'(if1.wr_data_out);
               m_rr = if1.rd_req_out; m_ra = 32'(if1.rd_addr_out); m_tx = if1.tx_data_out; m_fe = if1.frame_error_out; end
      default: begin m_wv = if2.wr_valid_out; m_wa = 32'(if2.wr_addr_out); m_wd = 32'(if2.wr_data_out);
               m_rr = if2.rd_req_out; m_ra = 32'(if2.rd_addr_out); m_tx = if2.tx_data_out; m_fe = if2.frame_error_out; end
    endcase
  end

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { bit chk; logic [7:0] v; } tx_t;

  logic [7:0]  bq [$];
  wr_t         wq [$];
  logic [31:0] rq [$];
  tx_t         txq [$];
  int          exp_err = 0;
  int          err_seen = 0;
  bit          exp_rd = 0;
  int          bidx = 0;
  logic [31:0] hold_a [3] = '{0, 0, 0};
  logic [31:0] hold_d [3] = '{0, 0, 0};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Frame-level model: derive every expected bus event from the byte list.
  task automatic model(input int d);
    logic [7:0]  h;
    logic [31:0] msk, base, v;
    int n, db, nw;
    bit burst;
    h = bq[0]; n = bq.size() - 1; db = DB[d];
    burst = (BE[d] != 0) && h[6];
    msk = (32'd1 << AW[d]) - 1;
    base = 32'(h) & msk;
    wq.delete(); rq.delete(); txq.delete();
    exp_rd = h[7];
    exp_err = 0;
    if (!h[7]) begin
      nw = burst ? n / db : ((n >= db) ? 1 : 0);
      for (int w = 0; w < nw; w++) begin
        v = 0;
        for (int k = 0; k < db; k++) v = (v << 8) | 32'(bq[1 + w*db + k]);
        wq.push_back('{(base + 32'(w)) & msk, v});
      end
      if (burst) exp_err = (n % db != 0) ? 1 : 0;
      else       exp_err = (n > db) ? n - db : ((n > 0 && n < db) ? 1 : 0);
    end else begin
      nw = burst ? n / db + 1 : 1;
      for (int r = 0; r < nw; r++) rq.push_back((base + 32'(r)) & msk);
      exp_err = (!burst && n > db) ? n - db : 0;
      for (int i = 0; i < n; i++) begin
        v = rdw((base + 32'(i / db)) & msk) >> (8 * (db - 1 - i % db));
        txq.push_back('{burst || i < db, v[7:0]});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      bidx = 0;
    end else begin
      if (m_wv) begin
        if (wq.size() == 0) chk("wr_unexpected", 32'(m_wv), 32'd0);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", m_wa, w.a);
          chk("wr_data", m_wd, w.d);
          hold_a[sel] = w.a; hold_d[sel] = w.d;
        end
      end else if (dv) begin
        chk("wr_hold_addr", m_wa, hold_a[sel]);
        chk("wr_hold_data", m_wd, hold_d[sel]);
      end
      if (m_rr) begin
        if (rq.size() == 0) chk("rd_unexpected", 32'(m_rr), 32'd0);
        else chk("rd_addr", m_ra, rq.pop_front());
      end
      if (m_fe) err_seen++;
      if (tv && dv) begin
        if (exp_rd && bidx > 0) begin
          if (txq.size() == 0) chk("tx_extra_byte", 32'(bidx), 32'd0);
          else begin
            tx_t t;
            t = txq.pop_front();
            if (t.chk) chk("tx_byte", 32'(m_tx), 32'(t.v));
          end
        end
        bidx++;
      end else if (!tv) begin
        bidx = 0;
      end
    end
  end

  task automatic send_bytes();
    @(posedge clk); #1 tv = 1'b1;
    foreach (bq[i]) begin
      @(posedge clk); #1 din = bq[i]; dv = 1'b1;
      @(posedge clk); #1 dv = 1'b0;
      if (i != bq.size() - 1) repeat (3) @(posedge clk);
    end
  endtask

  task automatic run(input int d);
    sel = d;
    model(d);
    send_bytes();
    repeat (3) @(posedge clk);
    #1 tv = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("writes_missing", 32'(wq.size()), 32'd0);
    chk("reads_missing", 32'(rq.size()), 32'd0);
    chk("frame_errors", 32'(err_seen), 32'(exp_err));
    err_seen = 0; exp_rd = 0; txq.delete();
  endtask

  // Reset lands right after the last listed byte is sampled.
  task automatic reset_mid(input int d);
    sel = d;
    wq.delete(); rq.delete(); txq.delete(); exp_rd = 0; exp_err = 0;
    send_bytes();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_wr_valid", 32'(m_wv), 32'd0);
      chk("rst_rd_req", 32'(m_rr), 32'd0);
      chk("rst_err", 32'(m_fe), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0; tv = 1'b0;
    for (int k = 0; k < 3; k++) begin hold_a[k] = 0; hold_d[k] = 0; end
    @(negedge clk);
    chk("rst_wr_data", m_wd, 32'd0);
    chk("rst_wr_addr", m_wa, 32'd0);
    chk("rst_err_count", 32'(err_seen), 32'd0);
    err_seen = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("reset_wr_valid", 32'(m_wv), 32'd0);
      chk("reset_wr_data", m_wd, 32'd0);
      chk("reset_wr_addr", m_wa, 32'd0);
      chk("reset_rd_req", 32'(m_rr), 32'd0);
      chk("reset_rd_addr", m_ra, 32'd0);
      chk("reset_tx", 32'(m_tx), 32'd0);
      chk("reset_err", 32'(m_fe), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b0;

    bq = '{8'h05, 8'h12, 8'h34}; model(0);
    chk("pin_single_addr", wq[0].a, 32'd5);
    chk("pin_single_data", wq[0].d, 32'h1234);
    run(0);

    bq = '{8'h5F, 8'hAB, 8'hCD, 8'hEF, 8'h01}; model(0);
    chk("pin_burst_wrap_addr", wq[1].a, 32'd0);
    chk("pin_burst_wrap_data", wq[1].d, 32'hEF01);
    run(0);

    bq = '{8'h41, 8'h12, 8'h34, 8'h56}; model(1);
    chk("pin_noburst_writes", 32'(wq.size()), 32'd1);
    chk("pin_noburst_err", 32'(exp_err), 32'd1);
    run(1);

    bq = '{8'h83, 8'h00, 8'h00}; model(0);
    chk("pin_read_addr", rq[0], 32'd3);
    chk("pin_read_tx0", 32'(txq[0].v), 32'hBE);
    chk("pin_read_tx1", 32'(txq[1].v), 32'hEF);
    run(0);

    bq = '{8'hC3, 8'h00, 8'h00, 8'h00, 8'h00}; run(0);

    bq = '{8'h02, 8'h11}; model(0);
    chk("pin_partial_err", 32'(exp_err), 32'd1);
    run(0);
    bq = '{8'h02, 8'h00, 8'h07}; run(0);

    bq = '{8'h04}; run(0);
    bq = '{8'h83, 8'h00, 8'h00, 8'h00}; run(1);

    bq = '{8'h3F, 8'h11, 8'h22, 8'h33}; model(2);
    chk("pin_p2_addr", wq[0].a, 32'd63);
    chk("pin_p2_data", wq[0].d, 32'h112233);
    run(2);

    bq = '{8'h3F, 8'h11, 8'h22}; reset_mid(2);
    bq = '{8'h05, 8'hAA, 8'hBB, 8'hCC}; run(2);

    bq = '{8'h05, 8'hAA, 8'hBB}; reset_mid(0);
    bq = '{8'h06, 8'h01, 8'h02}; run(0);

    bq = '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; run(2);
    bq = '{8'hBF, 8'h00, 8'h00, 8'h00}; run(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
